// File: rtl/cadence_pkg.sv
// Shared types and constants for the cadence measurement stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cadence_pkg;

  localparam int PER_W = 24;
  localparam int SCL_W = 8;

  localparam logic [PER_W-1:0] TMO_FAST = 24'h00_8000;
  localparam logic [PER_W-1:0] TMO_FULL = 24'hFF_FFFF;
  localparam logic [PER_W-1:0] CNT_MAX  = 24'hFF_FFFF;
  localparam logic [SCL_W-1:0] SCL_SAT  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Reduce a raw clock count to the 8-bit period reported downstream.
  // The fast variant keeps low-order bits so short simulated periods stay
  // visible, and saturates when anything above that window is set.
  function automatic logic [SCL_W-1:0] scale_per(input logic [PER_W-1:0] c,
                                                 input logic fast);
    logic [SCL_W-1:0] r;
    if (fast) begin
      r = (|c[23:15]) ? SCL_SAT : c[14:7];
    end else begin
      r = c[23:16];
    end
    return r;
  endfunction

endpackage

// File: rtl/cadence_meas_if.sv
// Bundle of the cadence pulse input and the measured period outputs.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are strobed, the consumer must sample on per_vld.
interface cadence_meas_if;
  import cadence_pkg::*;

  logic             cadence_rise;
  logic [SCL_W-1:0] cadence_per;
  logic [SCL_W-1:0] cadence_avg;
  logic             per_vld;
  logic             not_pedaling;

  // Upstream side: drives the pulse, observes the measurement.
  modport master (
    output cadence_rise,
    input  cadence_per,
    input  cadence_avg,
    input  per_vld,
    input  not_pedaling
  );

  // Measurement side: consumes the pulse, produces the measurement.
  modport slave (
    input  cadence_rise,
    output cadence_per,
    output cadence_avg,
    output per_vld,
    output not_pedaling
  );

endinterface

// File: rtl/cadence_avg4.sv
// Four-slot history of scaled periods and its truncated mean.
// Latency: slots update on the clock edge, average is combinational from the slots.
// Backpressure: none; one update accepted every cycle.
module cadence_avg4
  import cadence_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_all,
  input  logic             shift,
  input  logic             fill_ff,
  input  logic [SCL_W-1:0] din,
  output logic [SCL_W-1:0] avg
);

  logic [SCL_W-1:0] slot_q [4];
  logic [SCL_W-1:0] slot_d [4];
  logic [9:0]       sum;

  // Next slot contents: stop-fill beats a fresh start, which beats a shift.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (fill_ff) begin
      for (int i = 0; i < 4; i++) begin
        slot_d[i] = SCL_SAT;
      end
    end else if (load_all) begin
      for (int i = 0; i < 4; i++) begin
        slot_d[i] = din;
      end
    end else if (shift) begin
      slot_d[0] = din;
      slot_d[1] = slot_q[0];
      slot_d[2] = slot_q[1];
      slot_d[3] = slot_q[2];
    end
  end

  // Slot registers; reset to the "stopped" value so the mean reads FF.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= SCL_SAT;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Ten bits hold four 8-bit values without overflow; drop two bits to divide.
  always_comb begin
    sum = {2'b00, slot_q[0]} + {2'b00, slot_q[1]}
        + {2'b00, slot_q[2]} + {2'b00, slot_q[3]};
    avg = sum[9:2];
  end

endmodule

// File: rtl/cadence_meas.sv
// Measures clocks between cadence rises, reports scaled period, mean and stop flag.
// Latency: 1 cycle from a sampled rise to per_vld/cadence_per/cadence_avg.
// Backpressure: none; every rise is accepted, including back-to-back rises.
module cadence_meas
  import cadence_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  cadence_meas_if.slave  bus
);

  localparam logic [PER_W-1:0] TMO = FAST_SIM ? TMO_FAST : TMO_FULL;

  logic [PER_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [SCL_W-1:0] per_q, per_d;
  logic             vld_q, vld_d;
  logic             np_q, np_d;

  logic             rise;
  logic             tmo;
  logic [SCL_W-1:0] scaled;
  logic             load_all;
  logic             shift;
  logic             fill_ff;
  logic [SCL_W-1:0] avg;

  assign rise   = bus.cadence_rise;
  assign tmo    = (cnt_q == TMO);
  assign scaled = scale_per(cnt_q, FAST_SIM);

  // Period counter: restart at 1 on a rise, otherwise count up and stick at max.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = 24'd1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // FSM next state and per-cycle controls; a rise takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    vld_d    = 1'b0;
    load_all = 1'b0;
    shift    = 1'b0;
    fill_ff  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (rise) begin
          state_d  = RUN;
          per_d    = scaled;
          vld_d    = 1'b1;
          load_all = 1'b1;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rise) begin
          per_d = scaled;
          vld_d = 1'b1;
          shift = 1'b1;
        end else if (tmo) begin
          state_d = IDLE;
          per_d   = SCL_SAT;
          fill_ff = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    np_d = (state_d != RUN);
  end

  // Registered state, counter and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= SCL_SAT;
      vld_q   <= 1'b0;
      np_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      vld_q   <= vld_d;
      np_q    <= np_d;
    end
  end

  cadence_avg4 u_avg4 (
    .clk      (clk),
    .rst      (rst),
    .load_all (load_all),
    .shift    (shift),
    .fill_ff  (fill_ff),
    .din      (scaled),
    .avg      (avg)
  );

  assign bus.cadence_per  = per_q;
  assign bus.cadence_avg  = avg;
  assign bus.per_vld      = vld_q;
  assign bus.not_pedaling = np_q;

endmodule

// File: tb/tb_cadence_meas.sv
// Directed bench for cadence_meas with FAST_SIM scaling and timeout.
// Latency: checks outputs 1 time unit after each active edge.
// Backpressure: n/a.
module tb_cadence_meas;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cadence_meas_if bus_if ();

  cadence_meas #(.FAST_SIM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rise lands on the gap-th edge after the previous rise edge.
  task automatic pulse_after(input int gap);
    repeat (gap - 1) tick();
    bus_if.cadence_rise = 1'b1;
    tick();
    bus_if.cadence_rise = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] per, input logic [7:0] avg,
                           input logic vld, input logic np);
    check({tag, ".per"}, bus_if.cadence_per, per);
    check({tag, ".avg"}, bus_if.cadence_avg, avg);
    check({tag, ".vld"}, {7'd0, bus_if.per_vld}, {7'd0, vld});
    check({tag, ".np"},  {7'd0, bus_if.not_pedaling}, {7'd0, np});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.cadence_rise = 1'b0;

    // Reset held for three edges.
    repeat (3) tick();
    check_all("reset", 8'hFF, 8'hFF, 1'b0, 1'b1);
    rst = 1'b0;

    // First rise only arms the measurement.
    pulse_after(100);
    check_all("first_rise", 8'hFF, 8'hFF, 1'b0, 1'b1);

    // Second rise, 1280 clocks later: 1280>>7 = 0x0A into all slots.
    pulse_after(1280);
    check_all("second_rise", 8'h0A, 8'h0A, 1'b1, 1'b0);
    tick();
    check("strobe_one_cycle", {7'd0, bus_if.per_vld}, 8'h00);

    // Steady cadence continues.
    pulse_after(1279);
    check_all("steady", 8'h0A, 8'h0A, 1'b1, 1'b0);

    // Doubled gap: period 0x14, mean (10+10+10+20)/4 = 12.
    pulse_after(2560);
    check_all("avg_gap", 8'h14, 8'h0C, 1'b1, 1'b0);

    // Timeout: still running one edge before, stopped at t0+32768.
    repeat (32767) tick();
    check("pre_timeout.np", {7'd0, bus_if.not_pedaling}, 8'h00);
    check("pre_timeout.per", bus_if.cadence_per, 8'h14);
    tick();
    check_all("timeout", 8'hFF, 8'hFF, 1'b0, 1'b1);

    // Two rises bring it back to RUN with a fresh average.
    pulse_after(500);
    check_all("rearm", 8'hFF, 8'hFF, 1'b0, 1'b1);
    pulse_after(1280);
    check_all("rerun", 8'h0A, 8'h0A, 1'b1, 1'b0);

    // Rise coincides with timeout: saturated capture, stays in RUN.
    // Slots become FF,0A,0A,0A -> 285/4 = 71.
    pulse_after(32768);
    check_all("rise_at_tmo", 8'hFF, 8'h47, 1'b1, 1'b0);
    pulse_after(1280);
    check_all("after_sat", 8'h0A, 8'h47, 1'b1, 1'b0);

    // Reset coincident with a rise in RUN: rise ignored, reset values.
    tick();
    rst = 1'b1;
    bus_if.cadence_rise = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.cadence_rise = 1'b0;
    check_all("mid_reset", 8'hFF, 8'hFF, 1'b0, 1'b1);

    // After reset the next rise only arms again.
    pulse_after(1280);
    check_all("post_reset_rise", 8'hFF, 8'hFF, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cadence_meas.md
# cadence_meas

Cadence measurement stage of the sensor-conditioning path, directly downstream of the cadence glitch filter. It consumes the filter's single-cycle rising-edge pulse and measures the clock count between consecutive pedal-sensor rising edges. It produces a scaled 8-bit period, a 4-sample moving average and a valid strobe, and detects a stopped crank via timeout (`not_pedaling`). Outputs feed the assist/torque computation.

## Interface
- `FAST_SIM`, default 1: selects short timeout and low-order period scaling for simulation.
- `clk  in  1`: system clock, single clock domain.
- `rst  in  1`: reset, synchronous, active-high.
- `cadence_rise  in  1`: one-cycle pulse per filtered cadence rising edge.
- `cadence_per  out  8`: scaled latest period; `8'hFF` means stopped or saturated.
- `cadence_avg  out  8`: mean of the last 4 scaled periods.
- `per_vld  out  1`: one-cycle strobe; a new `cadence_per`/`cadence_avg` is valid.
- `not_pedaling  out  1`: high unless the FSM is in RUN.

## Operation
- 24-bit period counter `cnt`.
  - On a `cadence_rise` edge: `cnt <= 1`.
  - Otherwise: `cnt <= cnt+1`, saturating at `24'hFF_FFFF`.
  - The period captured at a rise is the pre-update `cnt`, i.e. the number of clock edges since the previous rise.
- Scaling of a captured value `c`:
  - FAST_SIM=1: `|c[23:15] ? 8'hFF : c[14:7]`.
  - FAST_SIM=0: `c[23:16]`.
- Timeout condition:
  - FAST_SIM=1: `cnt == 24'h00_8000`.
  - FAST_SIM=0: `cnt == 24'hFF_FFFF`.
- FSM states: IDLE, FIRST, RUN.
  - **IDLE** (reset state): on rise → FIRST. No capture, no `per_vld`.
  - **FIRST**: on rise → RUN; capture; load all 4 average slots with the scaled value; pulse `per_vld`. On timeout with no rise → IDLE.
  - **RUN**: on rise → capture; shift the scaled value into the 4-slot buffer, evicting the oldest; pulse `per_vld`; stay in RUN. On timeout with no rise → IDLE, with `cadence_per` and all buffer slots set to `8'hFF`.
- Rise and timeout in the same cycle: the rise wins. Capture proceeds; the scaled value saturates to `8'hFF` where applicable; the state does not drop to IDLE.
- `cadence_avg = (s0+s1+s2+s3) >> 2`.
  - Computed from the buffer registers with a 10-bit sum; truncation, no rounding.
- `not_pedaling = (state != RUN)`, registered with the state.

## Timing
- Reset values:
  - `cadence_per = 8'hFF`
  - `cadence_avg = 8'hFF` (all slots `8'hFF`)
  - `per_vld = 0`
  - `not_pedaling = 1`
  - `cnt = 0`
  - state IDLE
- A rise sampled at edge t updates `cadence_per`, the buffer and `cadence_avg`, and raises `per_vld`, all visible in cycle t+1. Latency is 1 cycle.
- `per_vld` is high exactly 1 cycle per accepted rise in FIRST/RUN. Back-to-back rises on consecutive edges produce back-to-back strobes with period 1.
- Timeout: with the last rise at edge t0, the FSM leaves RUN/FIRST at edge t0+32768 (FAST_SIM), so `not_pedaling` is high from cycle t0+32768+1.
- `rst` asserted in any state: all registers return to reset values at the next edge, and a pending rise in that cycle is ignored.
- Counter saturation: `cnt` holds `24'hFF_FFFF` and never wraps to 0.

## Structure
- Package `cadence_pkg` holds:
  - the state enum typedef (IDLE/FIRST/RUN);
  - `TMO_FAST = 24'h00_8000` and `TMO_FULL = 24'hFF_FFFF`;
  - period width 24 and scaled width 8.
- Sub-module `cadence_avg4` holds the 4-slot shift buffer with `load_all` and `shift` controls, the fill-to-FF control, the 10-bit adder and the `>>2`.
- The FSM, counter and scaling live in the top level.

## Test plan
- **Reset:** assert `rst` 3 cycles → `cadence_per=FF`, `cadence_avg=FF`, `per_vld=0`, `not_pedaling=1`.
- **Steady cadence:** rises every 1280 clocks (FAST_SIM) → first rise gives no `per_vld`. Second rise → `per_vld` pulse, `cadence_per=0x0A`, `cadence_avg=0x0A`, `not_pedaling=0`.
- **Averaging:** after steady 1280-clock rises, one 2560-clock gap → `cadence_per=0x14`, `cadence_avg=0x0C` (50/4 truncated).
- **Timeout:** in RUN, no rise for 32768 clocks → `not_pedaling` rises at t0+32769, `cadence_per=FF`, `cadence_avg=FF`. The next two rises return to RUN.
- **Simultaneous rise and timeout:** rise exactly at `cnt=0x8000` → `per_vld` pulse, `cadence_per=FF`, state remains RUN.
- **Mid-run reset:** `rst` pulse in RUN, coincident with a rise → no `per_vld`, all outputs at reset values the next cycle.
